spr_fetch: RTL and testbench
============================

Name: spr_fetch

Overview:
- Per-scanline sprite evaluation and pattern fetch engine. Feeds the 8 sprite render slots (spr_rend instances).
- On each line_start it scans the 64-entry OAM and selects up to 8 sprites intersecting the target scanline. It then fetches their two pattern planes, packs each into a 32-bit render word, and loads each slot with a one-cycle rend_now strobe.
- Sits between OAM/pattern memory and the sprite render slots, ahead of the sprite/background multiplexer.

Parameters:
- NUM_SLOTS, 8, number of render slots loaded per line.
- OAM_SPRITES, 64, OAM entries scanned (4 bytes each: Y, tile, attr, X).
- UNUSED_XPOS, 8'hFF, X position written to empty slots.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse; begin evaluation for scanline.
- scanline  in  8  target line; sampled on line_start.
- pt_sel  in  1  sprite pattern table select (pattern address bit 12).
- oam_addr  out  8  OAM byte address.
- oam_data  in  8  OAM read data; valid 1 cycle after oam_addr.
- pat_addr  out  13  pattern memory address.
- pat_data  in  8  pattern read data; valid 1 cycle after pat_addr.
- rend_buf  out  32  packed render word, shared by all slots.
- rend_now  out  NUM_SLOTS  one-hot slot load strobe.
- spr_count  out  4  sprites found this line (0..8).
- overflow  out  1  more than 8 sprites hit the line.
- busy  out  1  high from line_start until DONE.
- done  out  1  one-cycle pulse when all slots are loaded.

Behaviour:
- Reset values: all outputs 0. FSM returns to IDLE; the secondary store is cleared.
- rend_buf packing: [7:0] low plane, [15:8] high plane, [23:16] X, [25:24] palette (attr[1:0]), [29] priority (attr[5]), [30] hflip (attr[6]). All other bits are 0.
- Vflip (attr[7]) is applied here; the render slot never sees it.
- FSM states: IDLE -> EVAL_Y -> EVAL_CHK -> (COPY_T -> COPY_A -> COPY_X) -> ... -> FETCH_LO -> FETCH_HI -> LOAD -> ... -> DONE -> IDLE.
- Each OAM or pattern read takes 2 cycles: address is driven in the issue cycle, data is captured in the next.
- Hit test: row = {1'b0,scanline} - {1'b0,Y} in 9 bits; hit when row < 8 (unsigned), so a borrow means no hit. Sprite with Y=scanline hits at row 0.
- Timing per sprite: non-hit costs 2 cycles. Hit with count<8 costs 8 cycles and copies tile/attr/X into slot[count], then count++.
- Hit with count==8: set overflow, stop the scan, go to FETCH.
- Scan ends after sprite 63 (the address counter does not wrap).
- Fetch for slot i < count: r = vflip ? 7-row : row.
  - Low plane at {pt_sel, tile, 1'b0, r[2:0]}.
  - High plane at the same address with bit 3 set.
- LOAD for slot i:
  - rend_buf is updated in cycle N.
  - rend_now[i]=1 in cycle N+1 only.
  - rend_buf is held stable through N+2; the next rend_buf update is no earlier than N+3.
- Slots i >= count are still loaded, in order, with planes=0, X=UNUSED_XPOS and other fields 0. No pattern reads are issued for them.
- DONE: done=1 for one cycle, busy=0 the same cycle, then IDLE. spr_count and overflow hold until the next line_start.
- line_start while busy: abort immediately. Clear count and overflow, resample scanline, restart at EVAL_Y. No rend_now is issued for the aborted pass after the abort cycle.
- line_start in the same cycle as done: the restart wins, and done is still pulsed.
- Asynchronous reset mid-operation: rend_now drops immediately. No partial load is completed.

Optional Feature:
- Macro: SPR_8X16_EN.
- With the macro: input port spr_tall (1 bit) is added.
  - When spr_tall=1, hit when row < 16.
  - Pattern table comes from tile[0]; tile base is {tile[7:1], r[3]}; r = vflip ? 15-row : row.
  - pt_sel is ignored when spr_tall=1.
- Without the macro: the port is absent and only 8x8 sprites are supported.

Decomposition:
- Shared package spr_pkg:
  - rend_buf field position localparams (PLANE_LO, PLANE_HI, XPOS, PAL, PRIO, HFLIP).
  - NUM_SLOTS and OAM_SPRITES.
  - FSM state enum.
  - Struct for a secondary entry (row, tile, attr, x).
- Sub-module spr_sec_oam: 8-entry secondary store with clear, write-at-count and indexed read; also used by later debug readout.

Test Plan:
- Empty OAM (all Y=8'hF0), scanline=20, line_start -> 8 rend_now pulses in order slot0..7, each with rend_buf=32'h00FF0000; spr_count=0, overflow=0, done pulse.
- Sprite 5 with Y=10, tile=8'h3C, attr=8'h41, X=8'h80, pat_data=addr[7:0]; scanline=13 -> pattern reads at 13'h03C3 and 13'h03CB; slot0 rend_buf=32'h4180CBC3 (hflip, palette 1); spr_count=1.
- Same sprite with attr=8'h80 (vflip), scanline=13 -> r=4, reads at 13'h03C4 and 13'h03CC.
- Boundaries: Y=scanline hits (row 0); Y=scanline-7 hits; Y=scanline-8 misses; Y=scanline+1 misses (borrow).
- Ten sprites with Y=50, scanline=52 -> slots hold OAM sprites 0..7; overflow=1; spr_count=8; scan stops at sprite 8.
- line_start re-pulsed mid-FETCH with a new scanline -> no stale rend_now; a full new pass completes with new data. rst_n low mid-LOAD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/spr_pkg.sv
// rtl/spr_pkg.sv - shared types, field positions and helpers for the sprite fetch engine
package spr_pkg;

    localparam int NUM_SLOTS   = 8;
    localparam int OAM_SPRITES = 64;
    localparam logic [7:0] UNUSED_XPOS = 8'hFF;

    // Bit positions inside the packed render word
    localparam int PLANE_LO = 0;
    localparam int PLANE_HI = 8;
    localparam int XPOS     = 16;
    localparam int PAL      = 24;
    localparam int PRIO     = 29;
    localparam int HFLIP    = 30;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EVAL_Y,
        S_EVAL_CHK,
        S_COPY_T,
        S_COPY_A,
        S_COPY_X,
        S_FETCH_LO,
        S_FETCH_HI,
        S_LOAD,
        S_DONE
    } state_e;

    // One selected sprite: row is the line offset inside the sprite (4 bits covers 8x16)
    typedef struct packed {
        logic [3:0] row;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
    } sec_entry_t;

    localparam int SEC_W = $bits(sec_entry_t);

    // Build the render word; vflip (attr[7]) is consumed during fetch and never packed
    function automatic logic [31:0] pack_rend(input logic [7:0] lo, input logic [7:0] hi,
                                              input logic [7:0] x, input logic [7:0] attr);
        logic [31:0] w;
        w = '0;
        w[PLANE_LO +: 8] = lo;
        w[PLANE_HI +: 8] = hi;
        w[XPOS +: 8]     = x;
        w[PAL +: 2]      = attr[1:0];
        w[PRIO]          = attr[5];
        w[HFLIP]         = attr[6];
        return w;
    endfunction

endpackage

// File: rtl/spr_sec_oam.sv
// rtl/spr_sec_oam.sv - 8-entry secondary sprite store with clear, write-at-count and indexed read
module spr_sec_oam
    import spr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [2:0]       wr_idx,
    input  logic [SEC_W-1:0] wr_data,
    input  logic [2:0]       rd_idx,
    output logic [SEC_W-1:0] rd_data
);

    sec_entry_t mem_q [NUM_SLOTS];

    // Entry storage: cleared on reset and at every new line, written at the current count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx] <= sec_entry_t'(wr_data);
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/spr_fetch.sv
// rtl/spr_fetch.sv - per-scanline sprite evaluation and pattern fetch engine (8x16 mode under SPR_8X16_EN)
module spr_fetch
    import spr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_start,
    input  logic [7:0]           scanline,
    input  logic                 pt_sel,
`ifdef SPR_8X16_EN
    input  logic                 spr_tall,
`endif
    output logic [7:0]           oam_addr,
    input  logic [7:0]           oam_data,
    output logic [12:0]          pat_addr,
    input  logic [7:0]           pat_data,
    output logic [31:0]          rend_buf,
    output logic [NUM_SLOTS-1:0] rend_now,
    output logic [3:0]           spr_count,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    state_e     state_q, state_d;
    logic       ph_q, ph_d;            // 0 = address issue cycle, 1 = data capture cycle
    logic [5:0] idx_q, idx_d;          // OAM sprite under evaluation
    logic [2:0] slot_q, slot_d;        // render slot being fetched/loaded
    logic [1:0] ld_q, ld_d;            // LOAD sub-cycle: 0 pack, 1 word visible, 2 strobe
    logic [3:0] count_q;
    logic       ovf_q;
    logic [7:0] scan_q;
    logic [3:0] row_q;
    logic [7:0] tile_q, attr_q, lo_q, hi_q;
    logic [31:0] rend_q;

    logic        tall;
`ifdef SPR_8X16_EN
    assign tall = spr_tall;
`else
    assign tall = 1'b0;
`endif

    logic [8:0] row_calc;
    logic       hit;
    logic       slot_full;
    logic [2:0] slot_nxt;
    logic [SEC_W-1:0] rd_raw;
    sec_entry_t rd_ent;
    logic [3:0] r_lim, r;
    logic [12:0] pat_base;

    // A borrow in the 9-bit subtraction lands above the limit, so sprites below the line miss
    assign row_calc  = {1'b0, scan_q} - {1'b0, oam_data};
    assign hit       = row_calc < (tall ? 9'd16 : 9'd8);
    assign slot_full = {1'b0, slot_q} < count_q;
    assign slot_nxt  = slot_q + 3'd1;
    assign rd_ent    = sec_entry_t'(rd_raw);
    assign r_lim     = tall ? 4'd15 : 4'd7;
    assign r         = rd_ent.attr[7] ? (r_lim - rd_ent.row) : rd_ent.row;
    assign pat_base  = tall ? {rd_ent.tile[0], rd_ent.tile[7:1], r[3], 1'b0, r[2:0]}
                            : {pt_sel, rd_ent.tile, 1'b0, r[2:0]};

    spr_sec_oam u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (line_start),
        .wr_en   (state_q == S_COPY_X && ph_q && !line_start),
        .wr_idx  (count_q[2:0]),
        .wr_data ({row_q, tile_q, attr_q, oam_data}),
        .rd_idx  (slot_q),
        .rd_data (rd_raw)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ph_q    <= 1'b0;
            idx_q   <= '0;
            slot_q  <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            ld_q    <= ld_d;
        end
    end

    // Next-state logic; line_start always restarts evaluation, even mid-pass or on done
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        ld_d    = ld_q;
        if (line_start) begin
            state_d = S_EVAL_Y;
            ph_d    = 1'b0;
            idx_d   = '0;
            slot_d  = '0;
            ld_d    = '0;
        end else begin
            case (state_q)
                S_EVAL_Y: state_d = S_EVAL_CHK;
                S_EVAL_CHK: begin
                    if (hit && count_q == 4'd8) begin
                        state_d = S_FETCH_LO;
                    end else if (hit) begin
                        state_d = S_COPY_T;
                    end else if (idx_q == 6'd63) begin
                        state_d = (count_q != 4'd0) ? S_FETCH_LO : S_LOAD;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_EVAL_Y;
                    end
                end
                S_COPY_T: begin
                    ph_d = ~ph_q;
                    if (ph_q) state_d = S_COPY_A;
                end
                S_COPY_A: begin
                    ph_d = ~ph_q;
                    if (ph_q) state_d = S_COPY_X;
                end
                S_COPY_X: begin
                    ph_d = ~ph_q;
                    if (ph_q) begin
                        if (idx_q == 6'd63) begin
                            state_d = S_FETCH_LO;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            state_d = S_EVAL_Y;
                        end
                    end
                end
                S_FETCH_LO: begin
                    ph_d = ~ph_q;
                    if (ph_q) state_d = S_FETCH_HI;
                end
                S_FETCH_HI: begin
                    ph_d = ~ph_q;
                    if (ph_q) state_d = S_LOAD;
                end
                S_LOAD: begin
                    ld_d = ld_q + 2'd1;
                    if (ld_q == 2'd2) begin
                        ld_d = 2'd0;
                        if (slot_q == 3'd7) begin
                            state_d = S_DONE;
                        end else begin
                            slot_d  = slot_nxt;
                            state_d = ({1'b0, slot_nxt} < count_q) ? S_FETCH_LO : S_LOAD;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: captured OAM fields, planes, count/overflow and the shared render word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            scan_q  <= '0;
            row_q   <= '0;
            tile_q  <= '0;
            attr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            rend_q  <= '0;
        end else if (line_start) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            scan_q  <= scanline;
        end else begin
            case (state_q)
                S_EVAL_CHK: begin
                    row_q <= row_calc[3:0];
                    if (hit && count_q == 4'd8) ovf_q <= 1'b1;
                end
                S_COPY_T:   if (ph_q) tile_q <= oam_data;
                S_COPY_A:   if (ph_q) attr_q <= oam_data;
                S_COPY_X:   if (ph_q) count_q <= count_q + 4'd1;
                S_FETCH_LO: if (ph_q) lo_q <= pat_data;
                S_FETCH_HI: if (ph_q) hi_q <= pat_data;
                S_LOAD: begin
                    if (ld_q == 2'd0)
                        rend_q <= slot_full ? pack_rend(lo_q, hi_q, rd_ent.x, rd_ent.attr)
                                            : pack_rend(8'h00, 8'h00, UNUSED_XPOS, 8'h00);
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so reset clears them without waiting for a clock
    always_comb begin
        oam_addr = 8'h00;
        pat_addr = 13'h0000;
        rend_now = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE:               busy = 1'b0;
            S_EVAL_Y, S_EVAL_CHK: oam_addr = {idx_q, 2'd0};
            S_COPY_T:             oam_addr = {idx_q, 2'd1};
            S_COPY_A:             oam_addr = {idx_q, 2'd2};
            S_COPY_X:             oam_addr = {idx_q, 2'd3};
            S_FETCH_LO:           pat_addr = pat_base;
            S_FETCH_HI:           pat_addr = pat_base | 13'h0008;
            S_LOAD:               if (ld_q == 2'd2) rend_now = NUM_SLOTS'(1) << slot_q;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign rend_buf  = rend_q;
    assign spr_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_spr_fetch.sv
// tb/tb_spr_fetch.sv - directed self-checking bench for spr_fetch
module tb_spr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  scanline = 8'h00;
    logic        pt_sel = 1'b0;
`ifdef SPR_8X16_EN
    logic        spr_tall = 1'b0;
`endif
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data = 8'h00;
    logic [12:0] pat_addr;
    logic [7:0]  pat_data = 8'h00;
    logic [31:0] rend_buf;
    logic [7:0]  rend_now;
    logic [3:0]  spr_count;
    logic        overflow, busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  oam_mem [256];
    logic [7:0]  now_q [$];
    logic [31:0] buf_q [$];
    logic [12:0] pat_q [$];
    int          done_cnt = 0;
    logic [12:0] last_pat = 13'h0;
    logic [7:0]  max_oam = 8'h00;
    logic [31:0] exp_buf [8];

    spr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .scanline   (scanline),
        .pt_sel     (pt_sel),
`ifdef SPR_8X16_EN
        .spr_tall   (spr_tall),
`endif
        .oam_addr   (oam_addr),
        .oam_data   (oam_data),
        .pat_addr   (pat_addr),
        .pat_data   (pat_data),
        .rend_buf   (rend_buf),
        .rend_now   (rend_now),
        .spr_count  (spr_count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous memories: one cycle read latency, pattern data = address low byte
    always @(posedge clk) begin
        oam_data <= oam_mem[oam_addr];
        pat_data <= pat_addr[7:0];
    end

    // Observation log sampled on the falling edge
    always @(negedge clk) begin
        if (rend_now != 8'h00) begin
            now_q.push_back(rend_now);
            buf_q.push_back(rend_buf);
        end
        if (done) done_cnt++;
        if (pat_addr != 13'h0 && pat_addr != last_pat) pat_q.push_back(pat_addr);
        last_pat = pat_addr;
        if (oam_addr > max_oam) max_oam = oam_addr;
    end

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam_mem[i] = (i % 4 == 0) ? 8'hF0 : 8'h00;
    endtask

    task automatic set_spr(input int n, input logic [7:0] y, input logic [7:0] t,
                           input logic [7:0] a, input logic [7:0] x);
        oam_mem[4*n]   = y;
        oam_mem[4*n+1] = t;
        oam_mem[4*n+2] = a;
        oam_mem[4*n+3] = x;
    endtask

    task automatic set_exp_empty();
        for (int i = 0; i < 8; i++) exp_buf[i] = 32'h00FF0000;
    endtask

    task automatic start_line(input logic [7:0] s);
        @(posedge clk);
        #1;
        now_q.delete();
        buf_q.delete();
        pat_q.delete();
        done_cnt = 0;
        last_pat = 13'h0;
        max_oam  = 8'h00;
        scanline   = s;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({oam_addr, pat_addr, rend_buf, rend_now} !== 61'h0) begin
            errors++;
            $display("FAIL reset_bus: got oam=%h pat=%h buf=%h now=%h, expected all 0", oam_addr, pat_addr, rend_buf, rend_now);
        end
        checks++;
        if ({spr_count, overflow, busy, done} !== 7'h0) begin
            errors++;
            $display("FAIL reset_status: got cnt=%0d ovf=%b busy=%b done=%b, expected 0", spr_count, overflow, busy, done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_empty();
        bit ok;
        clear_oam();
        set_exp_empty();
        start_line(8'd20);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL empty_done: got timeout, expected done pulse"); end
        checks++;
        if (now_q.size() != 8 || done_cnt != 1) begin
            errors++; $display("FAIL empty_pulses: got %0d pulses %0d dones, expected 8 and 1", now_q.size(), done_cnt);
        end
        for (int i = 0; i < now_q.size() && i < 8; i++) begin
            checks++;
            if (now_q[i] !== 8'(1 << i) || buf_q[i] !== exp_buf[i]) begin
                errors++; $display("FAIL empty_slot%0d: got now=%h buf=%h, expected now=%h buf=%h", i, now_q[i], buf_q[i], 8'(1 << i), exp_buf[i]);
            end
        end
        checks++;
        if (spr_count !== 4'd0 || overflow !== 1'b0 || pat_q.size() != 0 || max_oam !== 8'd252) begin
            errors++; $display("FAIL empty_status: got cnt=%0d ovf=%b reads=%0d maxoam=%0d, expected 0 0 0 252", spr_count, overflow, pat_q.size(), max_oam);
        end
    endtask

    task automatic test_single(input logic [7:0] attr, input logic psel, input logic [7:0] line,
                               input logic [12:0] exp_lo, input logic [31:0] exp_w);
        bit ok;
        clear_oam();
        set_spr(5, 8'd10, 8'h3C, attr, 8'h80);
        pt_sel = psel;
        set_exp_empty();
        exp_buf[0] = exp_w;
        start_line(line);
        wait_done(ok);
        pt_sel = 1'b0;
        checks++;
        if (!ok || spr_count !== 4'd1 || overflow !== 1'b0) begin
            errors++; $display("FAIL single_status attr=%h: got ok=%b cnt=%0d ovf=%b, expected 1 1 0", attr, ok, spr_count, overflow);
        end
        checks++;
        if (pat_q.size() != 2 || pat_q[0] !== exp_lo || pat_q[1] !== (exp_lo | 13'h0008)) begin
            errors++; $display("FAIL single_reads attr=%h: got n=%0d first=%h, expected %h then %h", attr, pat_q.size(), (pat_q.size() > 0) ? pat_q[0] : 13'h0, exp_lo, exp_lo | 13'h0008);
        end
        checks++;
        if (now_q.size() != 8) begin errors++; $display("FAIL single_pulses attr=%h: got %0d, expected 8", attr, now_q.size()); end
        for (int i = 0; i < now_q.size() && i < 8; i++) begin
            checks++;
            if (now_q[i] !== 8'(1 << i) || buf_q[i] !== exp_buf[i]) begin
                errors++; $display("FAIL single_slot%0d attr=%h: got now=%h buf=%h, expected now=%h buf=%h", i, attr, now_q[i], buf_q[i], 8'(1 << i), exp_buf[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        bit ok;
        clear_oam();
        set_spr(0, 8'd100, 8'h01, 8'h00, 8'h10);  // row 0: hit
        set_spr(1, 8'd93,  8'h02, 8'h00, 8'h20);  // row 7: hit
        set_spr(2, 8'd92,  8'h03, 8'h00, 8'h30);  // row 8: miss
        set_spr(3, 8'd101, 8'h04, 8'h00, 8'h40);  // borrow: miss
        set_exp_empty();
        exp_buf[0] = 32'h00101810;
        exp_buf[1] = 32'h00202F27;
        start_line(8'd100);
        wait_done(ok);
        checks++;
        if (!ok || spr_count !== 4'd2 || overflow !== 1'b0) begin
            errors++; $display("FAIL bound_status: got ok=%b cnt=%0d ovf=%b, expected 1 2 0", ok, spr_count, overflow);
        end
        checks++;
        if (now_q.size() != 8) begin errors++; $display("FAIL bound_pulses: got %0d, expected 8", now_q.size()); end
        for (int i = 0; i < now_q.size() && i < 8; i++) begin
            checks++;
            if (now_q[i] !== 8'(1 << i) || buf_q[i] !== exp_buf[i]) begin
                errors++; $display("FAIL bound_slot%0d: got now=%h buf=%h, expected now=%h buf=%h", i, now_q[i], buf_q[i], 8'(1 << i), exp_buf[i]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_oam();
        for (int i = 0; i < 10; i++) begin
            set_spr(i, 8'd50, 8'h40 + 8'(i), 8'h00, 8'h30 + 8'(i));
            if (i < 8) exp_buf[i] = {8'h00, 8'h30 + 8'(i), 8'(i * 16 + 10), 8'(i * 16 + 2)};
        end
        start_line(8'd52);
        wait_done(ok);
        checks++;
        if (!ok || spr_count !== 4'd8 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_status: got ok=%b cnt=%0d ovf=%b, expected 1 8 1", ok, spr_count, overflow);
        end
        checks++;
        if (max_oam !== 8'd32) begin errors++; $display("FAIL ovf_scan_stop: got max oam_addr=%0d, expected 32", max_oam); end
        checks++;
        if (now_q.size() != 8) begin errors++; $display("FAIL ovf_pulses: got %0d, expected 8", now_q.size()); end
        for (int i = 0; i < now_q.size() && i < 8; i++) begin
            checks++;
            if (now_q[i] !== 8'(1 << i) || buf_q[i] !== exp_buf[i]) begin
                errors++; $display("FAIL ovf_slot%0d: got now=%h buf=%h, expected now=%h buf=%h", i, now_q[i], buf_q[i], 8'(1 << i), exp_buf[i]);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen;
        clear_oam();
        set_spr(5, 8'd10, 8'h3C, 8'h41, 8'h80);
        set_exp_empty();
        exp_buf[0] = 32'h4180CCC4;
        start_line(8'd13);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (pat_addr != 13'h0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_reach_fetch: got timeout, expected pattern read"); end
        start_line(8'd14);
        wait_done(ok);
        checks++;
        if (!ok || now_q.size() != 8 || done_cnt != 1 || spr_count !== 4'd1) begin
            errors++; $display("FAIL abort_pass: got ok=%b pulses=%0d dones=%0d cnt=%0d, expected 1 8 1 1", ok, now_q.size(), done_cnt, spr_count);
        end
        for (int i = 0; i < now_q.size() && i < 8; i++) begin
            checks++;
            if (now_q[i] !== 8'(1 << i) || buf_q[i] !== exp_buf[i]) begin
                errors++; $display("FAIL abort_slot%0d: got now=%h buf=%h, expected now=%h buf=%h", i, now_q[i], buf_q[i], 8'(1 << i), exp_buf[i]);
            end
        end
    endtask

    task automatic test_restart_on_done();
        bit ok;
        clear_oam();
        start_line(8'd20);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL restart_first_done: got timeout, expected done"); end
        set_spr(0, 8'd20, 8'h3C, 8'h00, 8'h11);
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        now_q.delete();
        buf_q.delete();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got busy=%b, expected 1", busy); end
        wait_done(ok);
        checks++;
        if (!ok || now_q.size() != 8 || spr_count !== 4'd1) begin
            errors++; $display("FAIL restart_pass: got ok=%b pulses=%0d cnt=%0d, expected 1 8 1", ok, now_q.size(), spr_count);
        end
        checks++;
        if (buf_q.size() > 0 && buf_q[0] !== 32'h0011C8C0) begin
            errors++; $display("FAIL restart_slot0: got %h, expected 0011c8c0", buf_q[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        bit seen;
        clear_oam();
        start_line(8'd20);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (rend_now != 8'h00) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_reach_load: got timeout, expected rend_now"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rend_now, rend_buf, oam_addr, pat_addr} !== 61'h0 || {busy, done, overflow, spr_count} !== 7'h0) begin
            errors++; $display("FAIL rst_async: got now=%h buf=%h busy=%b done=%b, expected all 0", rend_now, rend_buf, busy, done);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        clear_oam();
        test_reset();
        test_empty();
        test_single(8'h41, 1'b0, 8'd13, 13'h03C3, 32'h4180CBC3);
        test_single(8'h80, 1'b0, 8'd13, 13'h03C4, 32'h0080CCC4);
        test_single(8'h23, 1'b1, 8'd10, 13'h13C0, 32'h2380C8C0);
        test_boundaries();
        test_overflow();
        test_abort();
        test_restart_on_done();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
